// File: rtl/ct_lsu_dcache_wport_arb_if.sv
// Dcache write-port bundle: agent requests/payloads in, grants and
// the registered dcwp bus out.
interface ct_lsu_dcache_wport_arb_if;
  logic        dcwp_block;
  logic        snp_req;
  logic        lfb_req;
  logic        icc_req;
  logic        wmb_req;
  logic [8:0]  snp_idx;
  logic [8:0]  lfb_idx;
  logic [8:0]  icc_idx;
  logic [8:0]  wmb_idx;
  logic [6:0]  snp_dirty_wen;
  logic [6:0]  snp_dirty_din;
  logic [6:0]  lfb_dirty_wen;
  logic [6:0]  lfb_dirty_din;
  logic [6:0]  icc_dirty_wen;
  logic [6:0]  icc_dirty_din;
  logic [6:0]  wmb_dirty_wen;
  logic [6:0]  wmb_dirty_din;
  logic [1:0]  lfb_tag_wen;
  logic [51:0] lfb_tag_din;
  logic        snp_grnt;
  logic        lfb_grnt;
  logic        icc_grnt;
  logic        wmb_grnt;
  logic        dcache_tag_gwen;
  logic [1:0]  dcache_tag_wen;
  logic [51:0] dcache_tag_din;
  logic        dcache_dirty_gwen;
  logic [6:0]  dcache_dirty_wen;
  logic [6:0]  dcache_dirty_din;
  logic [8:0]  dcache_idx;
  logic        dcwp_sw_inst;

  modport master (
    output dcwp_block,
    output snp_req, lfb_req, icc_req, wmb_req,
    output snp_idx, lfb_idx, icc_idx, wmb_idx,
    output snp_dirty_wen, snp_dirty_din,
    output lfb_dirty_wen, lfb_dirty_din,
    output icc_dirty_wen, icc_dirty_din,
    output wmb_dirty_wen, wmb_dirty_din,
    output lfb_tag_wen, lfb_tag_din,
    input  snp_grnt, lfb_grnt, icc_grnt, wmb_grnt,
    input  dcache_tag_gwen, dcache_tag_wen, dcache_tag_din,
    input  dcache_dirty_gwen, dcache_dirty_wen,
    input  dcache_dirty_din, dcache_idx, dcwp_sw_inst
  );

  modport slave (
    input  dcwp_block,
    input  snp_req, lfb_req, icc_req, wmb_req,
    input  snp_idx, lfb_idx, icc_idx, wmb_idx,
    input  snp_dirty_wen, snp_dirty_din,
    input  lfb_dirty_wen, lfb_dirty_din,
    input  icc_dirty_wen, icc_dirty_din,
    input  wmb_dirty_wen, wmb_dirty_din,
    input  lfb_tag_wen, lfb_tag_din,
    output snp_grnt, lfb_grnt, icc_grnt, wmb_grnt,
    output dcache_tag_gwen, dcache_tag_wen, dcache_tag_din,
    output dcache_dirty_gwen, dcache_dirty_wen,
    output dcache_dirty_din, dcache_idx, dcwp_sw_inst
  );
endinterface

// File: rtl/ct_lsu_dcache_wport_arb.sv
// Dcache tag/dirty write-port arbiter: snp > lfb > icc > wmb onto dcwp bus.
// Optional wmb anti-starvation promotion under LSU_DCWP_ANTISTARVE_EN.
module ct_lsu_dcache_wport_arb (
  input logic                          forever_cpuclk,
  input logic                          cpurst,
  ct_lsu_dcache_wport_arb_if.slave     dcwp
);

  logic        w_open;
  logic        w_promote;
  logic        w_snp;
  logic        w_lfb;
  logic        w_icc;
  logic        w_wmb;
  logic        w_any;
  logic [8:0]  w_idx;
  logic [6:0]  w_dwen;
  logic [6:0]  w_ddin;

  logic        r_tag_gwen;
  logic [1:0]  r_tag_wen;
  logic [51:0] r_tag_din;
  logic        r_dirty_gwen;
  logic [6:0]  r_dirty_wen;
  logic [6:0]  r_dirty_din;
  logic [8:0]  r_idx;
  logic        r_sw_inst;

  assign w_open = ~dcwp.dcwp_block & ~cpurst;

`ifdef LSU_DCWP_ANTISTARVE_EN
  logic [2:0] r_starve_cnt;

  assign w_promote = (r_starve_cnt == 3'd7) & dcwp.wmb_req;

  // Counts only cycles wmb lost arbitration on an open port
  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst)
      r_starve_cnt <= 3'd0;
    else if (~dcwp.wmb_req | w_wmb)
      r_starve_cnt <= 3'd0;
    else if (~dcwp.dcwp_block & (r_starve_cnt != 3'd7))
      r_starve_cnt <= r_starve_cnt + 3'd1;
  end
`else
  assign w_promote = 1'b0;
`endif

  always_comb begin
    w_snp = 1'b0;
    w_lfb = 1'b0;
    w_icc = 1'b0;
    w_wmb = 1'b0;
    if (w_open) begin
      priority case (1'b1)
        w_promote:    w_wmb = 1'b1;
        dcwp.snp_req: w_snp = 1'b1;
        dcwp.lfb_req: w_lfb = 1'b1;
        dcwp.icc_req: w_icc = 1'b1;
        dcwp.wmb_req: w_wmb = 1'b1;
        default: ;
      endcase
    end
  end

  assign w_any = w_snp | w_lfb | w_icc | w_wmb;

  assign dcwp.snp_grnt = w_snp;
  assign dcwp.lfb_grnt = w_lfb;
  assign dcwp.icc_grnt = w_icc;
  assign dcwp.wmb_grnt = w_wmb;

  always_comb begin
    w_idx  = dcwp.wmb_idx;
    w_dwen = dcwp.wmb_dirty_wen;
    w_ddin = dcwp.wmb_dirty_din;
    unique case (1'b1)
      w_snp: begin
        w_idx  = dcwp.snp_idx;
        w_dwen = dcwp.snp_dirty_wen;
        w_ddin = dcwp.snp_dirty_din;
      end
      w_lfb: begin
        w_idx  = dcwp.lfb_idx;
        w_dwen = dcwp.lfb_dirty_wen;
        w_ddin = dcwp.lfb_dirty_din;
      end
      w_icc: begin
        w_idx  = dcwp.icc_idx;
        w_dwen = dcwp.icc_dirty_wen;
        w_ddin = dcwp.icc_dirty_din;
      end
      default: ;
    endcase
  end

  // Enables pulse for one cycle; data/index hold across idle cycles
  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      r_tag_gwen   <= 1'b0;
      r_tag_wen    <= 2'b0;
      r_tag_din    <= 52'b0;
      r_dirty_gwen <= 1'b0;
      r_dirty_wen  <= 7'b0;
      r_dirty_din  <= 7'b0;
      r_idx        <= 9'b0;
      r_sw_inst    <= 1'b0;
    end else begin
      r_tag_gwen   <= w_lfb & (|dcwp.lfb_tag_wen);
      r_tag_wen    <= w_lfb ? dcwp.lfb_tag_wen : 2'b0;
      r_dirty_gwen <= w_any;
      r_dirty_wen  <= w_any ? w_dwen : 7'b0;
      r_sw_inst    <= w_icc;
      if (w_lfb)
        r_tag_din <= dcwp.lfb_tag_din;
      if (w_any) begin
        r_dirty_din <= w_ddin;
        r_idx       <= w_idx;
      end
    end
  end

  assign dcwp.dcache_tag_gwen   = r_tag_gwen;
  assign dcwp.dcache_tag_wen    = r_tag_wen;
  assign dcwp.dcache_tag_din    = r_tag_din;
  assign dcwp.dcache_dirty_gwen = r_dirty_gwen;
  assign dcwp.dcache_dirty_wen  = r_dirty_wen;
  assign dcwp.dcache_dirty_din  = r_dirty_din;
  assign dcwp.dcache_idx        = r_idx;
  assign dcwp.dcwp_sw_inst      = r_sw_inst;

endmodule

// File: doc/ct_lsu_dcache_wport_arb.md
# ct_lsu_dcache_wport_arb

Arbitrates the four LSU agents that write the dcache tag and dirty arrays, and registers the winner onto the dcache write-port compare (dcwp) bus. The bus drives the SRAM write stage and is broadcast to every queue entry's dcache-state tracking logic. Each entry uses it to update its recorded valid/share/dirty/way state in the cycle the write lands. Agents are snoop (snp), line-fill refill (lfb), set&way cache op (icc) and write-merge store commit (wmb).

## Interface
Parameters:
- none (dcache index is fixed at 9 bits; tag payload is 2 ways × 26 bits).

Ports (name, direction, width, meaning):
- forever_cpuclk  in  1  clock.
- cpurst  in  1  reset, asynchronous, active-high.
- dcwp_block  in  1  LD/ST pipeline owns the arrays this cycle; no grant issued.
- snp_req, lfb_req, icc_req, wmb_req  in  1 each  write request; held until granted.
- snp_idx, lfb_idx, icc_idx, wmb_idx  in  9 each  set index.
- snp_dirty_wen/din, lfb_dirty_wen/din, icc_dirty_wen/din, wmb_dirty_wen/din  in  7 each  dirty-array bit enables/data. Layout: way0 {dirty,share,valid}=[2:0], way1=[5:3], bit6 = LRU.
- lfb_tag_wen  in  2  per-way tag enable.
- lfb_tag_din  in  52  {way1 tag, way0 tag}.
- snp_grnt, lfb_grnt, icc_grnt, wmb_grnt  out  1 each  combinational grant, same cycle as request.
- dcache_tag_gwen  out  1  registered, high = tag write on bus this cycle.
- dcache_tag_wen  out  2  registered.
- dcache_tag_din  out  52  registered.
- dcache_dirty_gwen  out  1  registered, high = dirty write on bus this cycle.
- dcache_dirty_wen  out  7  registered.
- dcache_dirty_din  out  7  registered.
- dcache_idx  out  9  registered.
- dcwp_sw_inst  out  1  registered, high = current write is a set&way op.

## Operation
- Grant is suppressed entirely while dcwp_block=1.
- Otherwise at most one grant per cycle. Fixed priority: snp > lfb > icc > wmb, unless the anti-starvation promotion applies (see Configuration).
- Winner selection:
  - lfb wins: tag_gwen=|lfb_tag_wen and dirty_gwen=1.
  - Any other agent wins: tag_gwen=0, tag_wen=0 and dirty_gwen=1.
- dcwp_sw_inst=1 only when icc wins.
- With no grant:
  - next cycle both gwens=0, tag_wen=0, dirty_wen=0 and sw_inst=0.
  - idx, tag_din and dirty_din hold their previous values.
- A requester that sees no grant keeps req and its payload stable. Dropping req without a grant is legal (abort); no state is kept for it.
- Back-to-back writes to the same idx are allowed; ordering on the bus equals grant order.

## Timing
- Grant in cycle N puts the write on the bus in cycle N+1; the bus is valid for exactly one cycle.
- Sustained throughput is one write per cycle.
- Reset values: every registered output is 0, the starvation counter is 0, and all grants are 0 while cpurst=1.
- Reset asserted mid-operation: the bus clears immediately (asynchronous); the requests pending at that point are discarded.
- Simultaneous requests from all four agents: snp is granted first; the others stay pending and are granted in priority order on later free cycles.

## Configuration
- LSU_DCWP_ANTISTARVE_EN defined:
  - A 3-bit saturating counter increments each cycle with wmb_req=1 & wmb_grnt=0 & dcwp_block=0.
  - It clears on wmb grant or wmb_req=0.
  - When the counter equals 7, wmb has top priority above snp. The counter clears on that grant.
- LSU_DCWP_ANTISTARVE_EN not defined: no counter; pure fixed priority; wmb can be starved indefinitely.

## Test plan
- Reset, then idle → all outputs 0.
- cpurst pulsed while a write is on the bus → bus 0 asynchronously, before the next clock edge.
- lfb_req with idx=0x1A5, tag_wen=2'b01, tag_din[25:0]=0x2ABCDEF, dirty_wen=0x07, dirty_din=0x01 → lfb_grnt same cycle. Next cycle:
  - tag_gwen=1, dirty_gwen=1, idx=0x1A5, tag_wen=01, dirty_din=0x01;
  - the cycle after, both gwens=0.
- snp, lfb, icc and wmb all request in cycle 0 and hold req until granted → grants in cycles 0/1/2/3 = snp/lfb/icc/wmb. dcwp_sw_inst=1 only in cycle 3, the cycle after icc's grant.
- dcwp_block=1 for 3 cycles with icc_req=1 → no grant. icc is granted in the first unblocked cycle; the following cycle dirty_gwen=1 and sw_inst=1.
- With the macro defined: wmb_req held while snp_req is held continuously → wmb_grnt in the 8th cycle. Without the macro: wmb_grnt never while snp_req is held.
